// File: rtl/mem_if_pkg.sv
// Shared load/store interface definitions: access-size encodings, responder FSM states
// and the byte-lane helpers used by data- and instruction-side responders.
package mem_if_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Wide enough for LATENCY+1 with LATENCY up to 15.
    localparam int               CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_ONE = 5'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a10);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << a10;
            SIZE_HALF: m = 4'b0011 << {a10[1], 1'b0};
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a10);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = a10[0];
            default:   mis = |a10;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store data replication plus lane mask, and load
// extraction with sign/zero extension. Low address bits are aligned down implicitly.
module dmem_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  a10_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sext_s;

    // Lane mask, store replication and load extension for the requested size.
    always_comb begin
        wmask_o = lane_mask(size_i, a10_i);
        sext_s  = ~unsigned_i;
        byte_s  = 8'(rword_i >> {a10_i, 3'b000});
        half_s  = 16'(rword_i >> {a10_i[1], 4'b0000});
        case (size_i)
            SIZE_BYTE: begin
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext_s & byte_s[7]}}, byte_s};
            end
            SIZE_HALF: begin
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext_s & half_s[15]}}, half_s};
            end
            default: begin
                wword_o = wdata_i;
                rdata_o = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready target for MEM-stage loads and stores on an internal
// byte-lane RAM. Define DMEM_ERR_EN to reject misaligned/out-of-range accesses via rsp_err.
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [31:0]         rsp_rdata_q;
    logic                write_q;
    logic                unsigned_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [1:0]          size_q;

    logic [31:0]         mem_q [0:(1<<DEPTH_LOG2)-1];

    logic [DEPTH_LOG2-1:0] idx_s;
    logic                in_range_s;
    logic                err_s;
    logic                access_ok_s;
    logic                fire_s;
    logic                we_s;
    logic [3:0]          wmask_s;
    logic [31:0]         wword_s;
    logic [31:0]         rword_s;
    logic [31:0]         rdata_s;

    assign idx_s      = addr_q[DEPTH_LOG2+1:2];
    assign in_range_s = (addr_q >> (DEPTH_LOG2 + 2)) == 32'd0;
`ifdef DMEM_ERR_EN
    assign err_s      = !in_range_s || is_misaligned(size_q, addr_q[1:0]);
`else
    assign err_s      = 1'b0;
`endif
    assign access_ok_s = in_range_s && !err_s;
    assign fire_s      = (state_q == WAIT) && (cnt_q == CNT_ONE);
    assign we_s        = fire_s && write_q && access_ok_s;
    assign rword_s     = mem_q[idx_s];

    dmem_lane_align u_align (
        .size_i     (size_q),
        .a10_i      (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .rword_i    (rword_s),
        .wmask_o    (wmask_s),
        .wword_o    (wword_s),
        .rdata_o    (rdata_s)
    );

    // Byte-lane RAM write at the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM; the counter runs LATENCY+1 down to 1 so the response
    // becomes visible LATENCY+1 cycles after the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            size_q      <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        write_q     <= req_write;
                        unsigned_q  <= req_unsigned;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        cnt_q       <= CNT_W'(LATENCY + 1);
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (!write_q && access_ok_s) ? rdata_s : 32'd0;
                        rsp_err_q   <= err_s;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: LATENCY=2 and LATENCY=0 instances checked against
// a byte-addressed reference memory. Honors DMEM_ERR_EN when defined.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid_v    [2];
    logic        req_write_v    [2];
    logic [31:0] req_addr_v     [2];
    logic [1:0]  req_size_v     [2];
    logic        req_unsigned_v [2];
    logic [31:0] req_wdata_v    [2];
    logic        rsp_ready_v    [2];

    logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;

    logic        obs_ready [2];
    logic        obs_valid [2];
    logic        obs_err   [2];
    logic [31:0] obs_rdata [2];

    always_comb begin
        obs_ready[0] = req_ready_a;  obs_ready[1] = req_ready_b;
        obs_valid[0] = rsp_valid_a;  obs_valid[1] = rsp_valid_b;
        obs_err[0]   = rsp_err_a;    obs_err[1]   = rsp_err_b;
        obs_rdata[0] = rsp_rdata_a;  obs_rdata[1] = rsp_rdata_b;
    end

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_a), .req_write(req_write_v[0]),
        .req_addr(req_addr_v[0]), .req_size(req_size_v[0]), .req_unsigned(req_unsigned_v[0]),
        .req_wdata(req_wdata_v[0]), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_v[0]),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_b), .req_write(req_write_v[1]),
        .req_addr(req_addr_v[1]), .req_size(req_size_v[1]), .req_unsigned(req_unsigned_v[1]),
        .req_wdata(req_wdata_v[1]), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_v[1]),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    int checks = 0;
    int errors = 0;

    // Byte-addressed reference memory, one per instance (4 KiB each).
    logic [7:0] mem_m [2][4096];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_access(input int w, input bit wr, input logic [31:0] a,
                                         input logic [1:0] sz, input bit uns,
                                         input logic [31:0] wd,
                                         output logic [31:0] rd, output bit er);
        int n;
        int ea;
        bit mis;
        bit oor;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        mis = (int'(a[1:0]) % n) != 0;
        oor = (a >= 32'd4096);
        rd  = 32'd0;
`ifdef DMEM_ERR_EN
        er  = mis || oor;
`else
        er  = 1'b0;
`endif
        if (er || oor) return;
        ea = int'(a[11:0]) - (int'(a[1:0]) % n);
        if (wr) begin
            for (int k = 0; k < n; k++) mem_m[w][ea + k] = wd[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[w][ea + k];
            if (!uns && n < 4 && v[8*n-1]) begin
                for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
            end
            rd = v;
        end
    endfunction

    task automatic wait_ready(input int w, output bit got);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (obs_ready[w] === 1'b1) got = 1'b1;
        end
    endtask

    task automatic drive_req(input int w, input bit wr, input logic [31:0] a,
                             input logic [1:0] sz, input bit uns, input logic [31:0] wd);
        req_valid_v[w]    = 1'b1;
        req_write_v[w]    = wr;
        req_addr_v[w]     = a;
        req_size_v[w]     = sz;
        req_unsigned_v[w] = uns;
        req_wdata_v[w]    = wd;
        @(posedge clk);
        #1 req_valid_v[w] = 1'b0;
    endtask

    task automatic txn(input int w, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                       input bit uns, input logic [31:0] wd, input int hold, input string tag,
                       output logic [31:0] rd_o);
        logic [31:0] exp_rd;
        logic [31:0] held;
        bit          exp_er;
        bit          got;
        int          k;
        rd_o = 32'd0;
        wait_ready(w, got);
        chk({tag, "/req_ready"}, 32'(got), 32'd1);
        if (!got) return;
        model_access(w, wr, a, sz, uns, wd, exp_rd, exp_er);
        drive_req(w, wr, a, sz, uns, wd);
        @(negedge clk);
        chk({tag, "/no_early_rsp"}, 32'(obs_valid[w]), 32'd0);
        got = 1'b0;
        k = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (obs_valid[w] === 1'b1) begin
                got = 1'b1;
                k = i;
            end
        end
        chk({tag, "/latency"}, 32'(k), (w == 0) ? 32'd3 : 32'd1);
        if (!got) return;
        rd_o = obs_rdata[w];
        chk({tag, "/rdata"}, obs_rdata[w], exp_rd);
        chk({tag, "/err"}, 32'(obs_err[w]), 32'(exp_er));
        held = obs_rdata[w];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(obs_valid[w]), 32'd1);
            chk({tag, "/hold_rdata"}, obs_rdata[w], held);
            chk({tag, "/hold_ready"}, 32'(obs_ready[w]), 32'd0);
        end
        rsp_ready_v[w] = 1'b1;
        @(posedge clk);
        #1 rsp_ready_v[w] = 1'b0;
        @(negedge clk);
        chk({tag, "/rsp_done"}, 32'(obs_valid[w]), 32'd0);
        chk({tag, "/ready_again"}, 32'(obs_ready[w]), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] ra;
        logic [1:0]  rs;
        bit          got;

        reset = 1'b1;
        for (int w = 0; w < 2; w++) begin
            req_valid_v[w] = 1'b0;  req_write_v[w] = 1'b0;  req_addr_v[w] = 32'd0;
            req_size_v[w] = 2'd0;   req_unsigned_v[w] = 1'b0; req_wdata_v[w] = 32'd0;
            rsp_ready_v[w] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("reset/req_ready", 32'(obs_ready[w]), 32'd0);
            chk("reset/rsp_valid", 32'(obs_valid[w]), 32'd0);
            chk("reset/rsp_rdata", obs_rdata[w], 32'd0);
            chk("reset/rsp_err", 32'(obs_err[w]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("release/ready_a", 32'(obs_ready[0]), 32'd1);
        chk("release/ready_b", 32'(obs_ready[1]), 32'd1);

        txn(0, 1'b1, 32'h0, 2'd2, 1'b0, 32'h01020304, 0, "pre_w0", rd);
        txn(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, "t1_store", rd);
        txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, "t1_load", rd);
        chk("t1_const", rd, 32'hDEADBEEF);

        txn(0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h0000007F, 0, "t2_store_b", rd);
        txn(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'd0, 0, "t2_load_b", rd);
        chk("t2_const", rd, 32'h0000007F);
        txn(0, 1'b0, 32'h12, 2'd1, 1'b0, 32'd0, 0, "t2_load_h", rd);

        txn(0, 1'b0, 32'h10, 2'd0, 1'b0, 32'd0, 0, "t3_signed", rd);
        chk("t3_signed_const", rd, 32'hFFFFFFEF);
        txn(0, 1'b0, 32'h10, 2'd0, 1'b1, 32'd0, 0, "t3_unsigned", rd);
        chk("t3_unsigned_const", rd, 32'h000000EF);

        txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 5, "t4_hold", rd);

        txn(0, 1'b0, 32'h12, 2'd2, 1'b0, 32'd0, 0, "t5_misalign", rd);
        txn(0, 1'b0, 32'h13, 2'd1, 1'b1, 32'd0, 0, "t5_misalign_h", rd);
        txn(0, 1'b1, 32'h4000, 2'd2, 1'b0, 32'hCAFEF00D, 0, "t5_oor_store", rd);
        txn(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'd0, 0, "t5_ram_kept", rd);
        chk("t5_ram_kept_const", rd, 32'h01020304);
        txn(0, 1'b0, 32'h4000, 2'd2, 1'b0, 32'd0, 0, "t5_oor_load", rd);

        txn(0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h11223344, 0, "t6_pre", rd);
        wait_ready(0, got);
        chk("t6/req_ready", 32'(got), 32'd1);
        drive_req(0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h12345678);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6/rsp_valid_in_reset", 32'(obs_valid[0]), 32'd0);
        chk("t6/req_ready_in_reset", 32'(obs_ready[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        txn(0, 1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 0, "t6_load", rd);
        chk("t6_old_const", rd, 32'h11223344);

        txn(1, 1'b1, 32'h40, 2'd2, 1'b0, 32'hA5A55A5A, 0, "l0_store", rd);
        txn(1, 1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 0, "l0_load", rd);
        chk("l0_const", rd, 32'hA5A55A5A);
        txn(1, 1'b0, 32'h41, 2'd0, 1'b0, 32'd0, 2, "l0_byte", rd);

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 64; i++) begin
                txn(w, 1'b1, 32'h100 + 32'(4 * i), 2'd2, 1'b0, $urandom, 0, "fill", rd);
            end
        end
        for (int i = 0; i < 120; i++) begin
            ra = 32'h100 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = ra | 32'h4000;
            rs = 2'($urandom_range(0, 3));
            txn(i % 2, 1'($urandom_range(0, 1)), ra, rs, 1'($urandom_range(0, 1)), $urandom,
                0, "rand", rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
